// File: rtl/rtc_calendar_core.sv
// rtc_calendar_core
// Real-time clock and calendar: a tick prescaler feeding a carry chain of
// second/minute/hour/day/month/year counters, with leap-year February, a
// field-addressed write port, a per-field increment without carry, 12/24-hour
// display decoding and an hour:minute alarm with a sticky flag.
//
// Ports
//   clock, reset        system clock, asynchronous active-high reset
//   run                 1 = prescaler advances, 0 = time frozen
//   set_valid           write strobe for set_field/set_value
//   set_field           0=sec 1=min 2=hour 3=day 4=month 5=year (6,7 invalid)
//   set_value           binary value to write
//   inc_req             increment strobe for set_field (wrapping, no carry)
//   mode_12h            display-hour format select
//   alarm_en            enables alarm matching
//   alarm_hour/minute   alarm time
//   alarm_ack           clears alarm_flag
//   second..year        current time and date
//   hour_disp, pm       display hour and afternoon indicator
//   tick                one-cycle pulse per second
//   alarm_hit           one-cycle pulse on alarm match
//   alarm_flag          sticky alarm indicator
//   set_error           one-cycle pulse on a rejected write
//
// Handshake: set_valid and inc_req are single-cycle strobes with no ready.
// The core always takes the request on the cycle it is presented; a write
// that fails its range check changes nothing and is reported by set_error on
// the following cycle. set_valid has priority over inc_req.
module rtc_calendar_core #(
    parameter int TICK_DIV   = 32768,
    parameter int PRESC_W    = 15,
    parameter int YEAR_MAX   = 99,
    parameter int RESET_YEAR = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       run,
    input  logic       set_valid,
    input  logic [2:0] set_field,
    input  logic [6:0] set_value,
    input  logic       inc_req,
    input  logic       mode_12h,
    input  logic       alarm_en,
    input  logic [4:0] alarm_hour,
    input  logic [5:0] alarm_minute,
    input  logic       alarm_ack,
    output logic [5:0] second,
    output logic [5:0] minute,
    output logic [4:0] hour,
    output logic [4:0] hour_disp,
    output logic       pm,
    output logic [4:0] day,
    output logic [3:0] month,
    output logic [6:0] year,
    output logic       tick,
    output logic       alarm_hit,
    output logic       alarm_flag,
    output logic       set_error
);

    localparam logic [PRESC_W-1:0] PRESC_TOP = PRESC_W'(TICK_DIV - 1);
    localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);
    localparam logic [6:0]         YMAX      = 7'(YEAR_MAX);
    localparam logic [6:0]         YRST      = 7'(RESET_YEAR);

    function automatic logic [4:0] month_days(input logic [3:0] m, input logic [6:0] y);
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: month_days = 5'd30;
            4'd2:                    month_days = (y[1:0] == 2'b00) ? 5'd29 : 5'd28;
            default:                 month_days = 5'd31;
        endcase
    endfunction

    logic [PRESC_W-1:0] presc, n_presc;
    logic               term;
    // t_* = values after the tick update only; n_* = final next values
    logic [5:0] t_sec, t_min, n_sec, n_min;
    logic [4:0] t_hour, t_day, n_hour, n_day, lim;
    logic [3:0] t_month, n_month;
    logic [6:0] t_year, n_year;
    logic       hit_d, err_d;

    assign term = run && (presc == PRESC_TOP);

    always_comb begin
        t_sec   = second;
        t_min   = minute;
        t_hour  = hour;
        t_day   = day;
        t_month = month;
        t_year  = year;
        if (term) begin
            if (second != 6'd59) begin
                t_sec = second + 6'd1;
            end else begin
                t_sec = 6'd0;
                if (minute != 6'd59) begin
                    t_min = minute + 6'd1;
                end else begin
                    t_min = 6'd0;
                    if (hour != 5'd23) begin
                        t_hour = hour + 5'd1;
                    end else begin
                        t_hour = 5'd0;
                        if (day < month_days(month, year)) begin
                            t_day = day + 5'd1;
                        end else begin
                            t_day = 5'd1;
                            if (month != 4'd12) begin
                                t_month = month + 4'd1;
                            end else begin
                                t_month = 4'd1;
                                t_year  = (year >= YMAX) ? 7'd0 : year + 7'd1;
                            end
                        end
                    end
                end
            end
        end

        // Alarm looks at the tick-updated time only, so writes cannot fire it.
        hit_d = term && alarm_en && (t_hour == alarm_hour) &&
                (t_min == alarm_minute) && (t_sec == 6'd0);

        n_presc = !run ? presc : (term ? '0 : presc + PRESC_ONE);
        n_sec   = t_sec;
        n_min   = t_min;
        n_hour  = t_hour;
        n_day   = t_day;
        n_month = t_month;
        n_year  = t_year;
        err_d   = 1'b0;
        lim     = 5'd31;

        if (set_valid) begin
            // Range checks use the pre-tick registers.
            case (set_field)
                3'd0: if (set_value <= 7'd59) begin
                          n_sec   = set_value[5:0];
                          n_presc = '0;
                      end else err_d = 1'b1;
                3'd1: if (set_value <= 7'd59) n_min = set_value[5:0];
                      else err_d = 1'b1;
                3'd2: if (set_value <= 7'd23) n_hour = set_value[4:0];
                      else err_d = 1'b1;
                3'd3: if (set_value >= 7'd1 && set_value <= {2'b00, month_days(month, year)})
                          n_day = set_value[4:0];
                      else err_d = 1'b1;
                3'd4: if (set_value >= 7'd1 && set_value <= 7'd12) begin
                          n_month = set_value[3:0];
                          lim     = month_days(set_value[3:0], t_year);
                          if (t_day > lim) n_day = lim;
                      end else err_d = 1'b1;
                3'd5: if (set_value <= YMAX) begin
                          n_year = set_value;
                          lim    = month_days(t_month, set_value);
                          if (t_day > lim) n_day = lim;
                      end else err_d = 1'b1;
                default: err_d = 1'b1;
            endcase
        end else if (inc_req) begin
            case (set_field)
                3'd0: n_sec  = (second == 6'd59) ? 6'd0 : second + 6'd1;
                3'd1: n_min  = (minute == 6'd59) ? 6'd0 : minute + 6'd1;
                3'd2: n_hour = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
                3'd3: n_day  = (day >= month_days(month, year)) ? 5'd1 : day + 5'd1;
                3'd4: begin
                    n_month = (month == 4'd12) ? 4'd1 : month + 4'd1;
                    lim     = month_days(n_month, t_year);
                    if (t_day > lim) n_day = lim;
                end
                3'd5: begin
                    n_year = (year >= YMAX) ? 7'd0 : year + 7'd1;
                    lim    = month_days(t_month, n_year);
                    if (t_day > lim) n_day = lim;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc      <= '0;
            second     <= 6'd0;
            minute     <= 6'd0;
            hour       <= 5'd0;
            day        <= 5'd1;
            month      <= 4'd1;
            year       <= YRST;
            tick       <= 1'b0;
            alarm_hit  <= 1'b0;
            alarm_flag <= 1'b0;
            set_error  <= 1'b0;
        end else begin
            presc      <= n_presc;
            second     <= n_sec;
            minute     <= n_min;
            hour       <= n_hour;
            day        <= n_day;
            month      <= n_month;
            year       <= n_year;
            tick       <= term;
            alarm_hit  <= hit_d;
            set_error  <= err_d;
            // A new hit outranks an acknowledge in the same cycle.
            if (hit_d)          alarm_flag <= 1'b1;
            else if (alarm_ack) alarm_flag <= 1'b0;
        end
    end

    always_comb begin
        pm = (hour >= 5'd12);
        if (!mode_12h)         hour_disp = hour;
        else if (hour == 5'd0) hour_disp = 5'd12;
        else if (hour > 5'd12) hour_disp = hour - 5'd12;
        else                   hour_disp = hour;
    end

endmodule

// File: tb/tb_rtc_calendar_core.sv
module tb_rtc_calendar_core;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b1;
    logic       set_valid = 1'b0;
    logic [2:0] set_field = 3'd0;
    logic [6:0] set_value = 7'd0;
    logic       inc_req = 1'b0;
    logic       mode_12h = 1'b0;
    logic       alarm_en = 1'b0;
    logic [4:0] alarm_hour = 5'd0;
    logic [5:0] alarm_minute = 6'd0;
    logic       alarm_ack = 1'b0;
    logic [5:0] second, minute;
    logic [4:0] hour, hour_disp, day;
    logic       pm, tick, alarm_hit, alarm_flag, set_error;
    logic [3:0] month;
    logic [6:0] year;

    int checks = 0;
    int errors = 0;
    logic [6:0] exp_q[$];
    int tick_seen;

    rtc_calendar_core #(
        .TICK_DIV(4), .PRESC_W(3), .YEAR_MAX(99), .RESET_YEAR(0)
    ) dut (
        .clock(clock), .reset(reset), .run(run),
        .set_valid(set_valid), .set_field(set_field), .set_value(set_value),
        .inc_req(inc_req), .mode_12h(mode_12h),
        .alarm_en(alarm_en), .alarm_hour(alarm_hour), .alarm_minute(alarm_minute),
        .alarm_ack(alarm_ack),
        .second(second), .minute(minute), .hour(hour), .hour_disp(hour_disp),
        .pm(pm), .day(day), .month(month), .year(year), .tick(tick),
        .alarm_hit(alarm_hit), .alarm_flag(alarm_flag), .set_error(set_error)
    );

    // clock / reset
    always #5 clock = ~clock;

    // driver tasks: everything changes and is sampled 1 time unit after posedge
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic write(input logic [2:0] f, input logic [6:0] v);
        set_valid = 1'b1;
        set_field = f;
        set_value = v;
        step();
        set_valid = 1'b0;
    endtask

    task automatic incr(input logic [2:0] f);
        inc_req   = 1'b1;
        set_field = f;
        step();
        inc_req   = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_date(input string tag, input int y, input int mo, input int d,
                              input int h, input int mi, input int s);
        check({tag, ".year"},   32'(year),   32'(y));
        check({tag, ".month"},  32'(month),  32'(mo));
        check({tag, ".day"},    32'(day),    32'(d));
        check({tag, ".hour"},   32'(hour),   32'(h));
        check({tag, ".minute"}, 32'(minute), 32'(mi));
        check({tag, ".second"}, 32'(second), 32'(s));
    endtask

    initial begin
        // reset state
        step(2);
        check_date("reset", 0, 1, 1, 0, 0, 0);
        check("reset.tick", 32'(tick), 32'd0);
        check("reset.flag", 32'(alarm_flag), 32'd0);
        check("reset.set_error", 32'(set_error), 32'd0);
        reset = 1'b0;

        // prescaler: {tick, second} for 8 cycles, tick every 4th
        exp_q = '{7'h00, 7'h00, 7'h00, 7'h41, 7'h01, 7'h01, 7'h01, 7'h42};
        for (int i = 0; i < 8; i++) begin
            logic [6:0] e;
            step();
            e = exp_q.pop_front();
            check("presc.tick_sec", 32'({tick, second}), 32'(e));
        end
        run = 1'b0;
        tick_seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (tick) tick_seen++;
        end
        check("frozen.ticks", 32'(tick_seen), 32'd0);
        check("frozen.second", 32'(second), 32'd2);
        run = 1'b1;
        step(4);
        check("resume.second", 32'(second), 32'd3);
        run = 1'b0;

        // year rollover of the day/month chain
        write(3'd5, 7'd23);
        write(3'd4, 7'd12);
        write(3'd3, 7'd31);
        write(3'd2, 7'd23);
        write(3'd1, 7'd59);
        write(3'd0, 7'd58);
        check("wr.set_error", 32'(set_error), 32'd0);
        run = 1'b1;
        step(7);
        check_date("pre_wrap", 23, 12, 31, 23, 59, 59);
        step();
        check_date("new_year", 24, 1, 1, 0, 0, 0);
        check("new_year.tick", 32'(tick), 32'd1);
        run = 1'b0;

        // leap February
        write(3'd4, 7'd2);
        write(3'd3, 7'd28);
        write(3'd2, 7'd23);
        write(3'd1, 7'd59);
        write(3'd0, 7'd59);
        run = 1'b1;
        step(4);
        run = 1'b0;
        check("leap.day", 32'(day), 32'd29);
        check("leap.month", 32'(month), 32'd2);

        // non-leap February
        write(3'd3, 7'd28);
        write(3'd5, 7'd23);
        write(3'd2, 7'd23);
        write(3'd1, 7'd59);
        write(3'd0, 7'd59);
        run = 1'b1;
        step(4);
        run = 1'b0;
        check_date("feb23", 23, 3, 1, 0, 0, 0);

        // clamp on month write
        write(3'd4, 7'd1);
        write(3'd3, 7'd31);
        write(3'd4, 7'd4);
        check("clamp.day", 32'(day), 32'd30);
        check("clamp.month", 32'(month), 32'd4);

        // rejected writes
        write(3'd2, 7'd24);
        check("bad_hour.err", 32'(set_error), 32'd1);
        check("bad_hour.hour", 32'(hour), 32'd0);
        step();
        check("bad_hour.pulse", 32'(set_error), 32'd0);
        write(3'd4, 7'd6);
        check("june.err", 32'(set_error), 32'd0);
        write(3'd3, 7'd31);
        check("bad_day.err", 32'(set_error), 32'd1);
        check("bad_day.day", 32'(day), 32'd30);
        write(3'd7, 7'd1);
        check("bad_field.err", 32'(set_error), 32'd1);
        step();
        check("bad_field.pulse", 32'(set_error), 32'd0);
        check_date("unchanged", 23, 6, 30, 0, 0, 0);

        // increment without carry
        write(3'd1, 7'd59);
        incr(3'd1);
        check("inc.minute", 32'(minute), 32'd0);
        check("inc.hour", 32'(hour), 32'd0);

        // 12/24-hour display
        mode_12h = 1'b1;
        write(3'd2, 7'd0);
        check("h0.disp", 32'(hour_disp), 32'd12);
        check("h0.pm", 32'(pm), 32'd0);
        write(3'd2, 7'd12);
        check("h12.disp", 32'(hour_disp), 32'd12);
        check("h12.pm", 32'(pm), 32'd1);
        write(3'd2, 7'd13);
        check("h13.disp", 32'(hour_disp), 32'd1);
        check("h13.pm", 32'(pm), 32'd1);
        mode_12h = 1'b0;
        #1;
        check("h13.disp24", 32'(hour_disp), 32'd13);

        // alarm 07:30
        alarm_en = 1'b1;
        alarm_hour = 5'd7;
        alarm_minute = 6'd30;
        write(3'd2, 7'd7);
        write(3'd1, 7'd29);
        write(3'd0, 7'd59);
        run = 1'b1;
        step(3);
        check("alarm.early", 32'(alarm_hit), 32'd0);
        step();
        check("alarm.hit", 32'(alarm_hit), 32'd1);
        check("alarm.flag", 32'(alarm_flag), 32'd1);
        check("alarm.minute", 32'(minute), 32'd30);
        step();
        check("alarm.hit_pulse", 32'(alarm_hit), 32'd0);
        check("alarm.flag_sticky", 32'(alarm_flag), 32'd1);
        run = 1'b0;
        alarm_ack = 1'b1;
        step();
        alarm_ack = 1'b0;
        check("alarm.ack", 32'(alarm_flag), 32'd0);
        write(3'd1, 7'd30);
        write(3'd0, 7'd0);
        check("alarm.write_hit", 32'(alarm_hit), 32'd0);
        step();
        check("alarm.write_flag", 32'(alarm_flag), 32'd0);

        // reset mid-operation
        run = 1'b1;
        step(2);
        reset = 1'b1;
        #1;
        check_date("mid_reset", 0, 1, 1, 0, 0, 0);
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
